// File: rtl/display_scanner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_scanner_pkg
//  Description : Shared types and constants for the multiplexed BCD display
//                scanner and its sequential binary-to-BCD converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_scanner_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BIN_W      = 14;
  localparam int BCD_W      = 16;

  localparam logic [BIN_W-1:0] MAX_VALUE   = 14'd9999;
  localparam logic [3:0]       GROUNDS_OFF = 4'b1111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_t;

endpackage : display_scanner_pkg
`default_nettype wire

// File: rtl/display_scanner_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble converter. Saturates the input to
//                9999, runs 14 add-3/shift cycles and publishes the packed
//                BCD result, which holds its old value while converting.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import display_scanner_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] value_in,
  input  logic             load,
  output logic             busy,
  output logic             overflow,
  output logic [BCD_W-1:0] result
);

  state_t           state;
  logic [BCD_W-1:0] bcd;
  logic [BIN_W-1:0] bin;
  logic [3:0]       shift_cnt;
  logic [BCD_W-1:0] bcd_adj;
  logic             too_big;
  logic [BIN_W-1:0] sat_value;

  assign too_big   = (value_in > MAX_VALUE);
  assign sat_value = too_big ? MAX_VALUE : value_in;

  // Per-nibble add-3 correction applied ahead of every shift
  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
      assign bcd_adj[4*g +: 4] = (bcd[4*g +: 4] >= 4'd5) ? (bcd[4*g +: 4] + 4'd3)
                                                          : bcd[4*g +: 4];
    end
  endgenerate

  // Conversion FSM and datapath; result only changes in UPDATE so the display never tears
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      bcd       <= '0;
      bin       <= '0;
      shift_cnt <= '0;
      result    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            bin       <= sat_value;
            bcd       <= '0;
            overflow  <= too_big;
            busy      <= 1'b1;
            shift_cnt <= '0;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          shift_cnt  <= shift_cnt + 4'd1;
          if (shift_cnt == 4'(BIN_W - 1)) begin
            state <= UPDATE;
          end
        end
        UPDATE: begin
          result <= bcd;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : bin2bcd_seq
`default_nettype wire

// File: rtl/display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : display_scanner
//  Description : Converts a 14-bit value to four BCD digits and scans them
//                onto a shared nibble bus with active-low digit grounds and
//                optional leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_LEADING = 1
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] value_in,
  input  logic             load,
  output logic             busy,
  output logic             overflow,
  output logic [3:0]       digit_out,
  output logic [3:0]       grounds
);

  localparam int PRE_W = $clog2(REFRESH_DIV);

  logic [BCD_W-1:0]      display;
  logic [PRE_W-1:0]      prescaler;
  logic [1:0]            index;
  logic [NUM_DIGITS-1:0] blank;
  logic [3:0]            nibble [NUM_DIGITS];

  bin2bcd_seq u_conv (
    .clk      (clk),
    .reset    (reset),
    .value_in (value_in),
    .load     (load),
    .busy     (busy),
    .overflow (overflow),
    .result   (display)
  );

  // Ones digit is never blanked so a zero value still lights a single "0"
  assign blank[0] = 1'b0;

  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nibble
      assign nibble[g] = display[4*g +: 4];
    end
    for (genvar g = 1; g < NUM_DIGITS; g++) begin : g_blank
      assign blank[g] = (BLANK_LEADING != 0) && (display[BCD_W-1:4*g] == '0);
    end
  endgenerate

  // Free-running refresh prescaler stepping the digit index on each wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      index     <= 2'd0;
    end else if (prescaler == PRE_W'(REFRESH_DIV - 1)) begin
      prescaler <= '0;
      index     <= index + 2'd1;
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

  // Registered digit bus and grounds for the currently selected digit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_out <= 4'h0;
      grounds   <= GROUNDS_OFF;
    end else begin
      digit_out <= nibble[index];
      grounds   <= blank[index] ? GROUNDS_OFF : ~(4'b0001 << index);
    end
  end

endmodule : display_scanner
`default_nettype wire

// File: tb/tb_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scanner
//  Description : Self-checking bench for display_scanner. Two instances
//                (blanking on / off) share stimulus and are compared every
//                cycle against a decimal-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scanner;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] value_in;
  logic        load;
  logic        busy_b, ovf_b, busy_n, ovf_n;
  logic [3:0]  dig_b, gnd_b, dig_n, gnd_n;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model state: decimal display value and cycle bookkeeping
  int m_disp, m_pend, m_cnt, m_pre, m_idx, m_ovf;
  int e_dig, e_gnd_b, e_gnd_n;

  display_scanner #(.REFRESH_DIV(DIV), .BLANK_LEADING(1)) dut_b (
    .clk(clk), .reset(reset), .value_in(value_in), .load(load),
    .busy(busy_b), .overflow(ovf_b), .digit_out(dig_b), .grounds(gnd_b)
  );

  display_scanner #(.REFRESH_DIV(DIV), .BLANK_LEADING(0)) dut_n (
    .clk(clk), .reset(reset), .value_in(value_in), .load(load),
    .busy(busy_n), .overflow(ovf_n), .digit_out(dig_n), .grounds(gnd_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int p10(input int i);
    int r = 1;
    for (int k = 0; k < i; k++) r = r * 10;
    return r;
  endfunction

  // Behavioural model: a load is a 15-cycle delay then display = min(v,9999)
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_disp = 0; m_pend = 0; m_cnt = 0; m_pre = 0; m_idx = 0; m_ovf = 0;
      e_dig = 0; e_gnd_b = 15; e_gnd_n = 15;
    end else begin
      e_dig   = (m_disp / p10(m_idx)) % 10;
      e_gnd_n = 15 & ~(1 << m_idx);
      e_gnd_b = (m_idx > 0 && m_disp < p10(m_idx)) ? 15 : e_gnd_n;
      if (m_cnt == 0) begin
        if (load) begin
          m_pend = (value_in > 9999) ? 9999 : int'(value_in);
          m_ovf  = (value_in > 9999) ? 1 : 0;
          m_cnt  = 15;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) m_disp = m_pend;
      end
      m_pre++;
      if (m_pre == DIV) begin
        m_pre = 0;
        m_idx = (m_idx + 1) % 4;
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy_b", busy_b, (m_cnt > 0) ? 1 : 0);
      check("ovf_b",  ovf_b,  m_ovf);
      check("dig_b",  dig_b,  e_dig);
      check("gnd_b",  gnd_b,  e_gnd_b);
      check("busy_n", busy_n, (m_cnt > 0) ? 1 : 0);
      check("ovf_n",  ovf_n,  m_ovf);
      check("dig_n",  dig_n,  e_dig);
      check("gnd_n",  gnd_n,  e_gnd_n);
    end
  end

  task automatic do_load(input int v);
    @(negedge clk);
    load     = 1'b1;
    value_in = 14'(v);
    @(negedge clk);
    load     = 1'b0;
  endtask

  initial begin
    int len;
    reset    = 1'b0;
    load     = 1'b0;
    value_in = '0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Idle scanning after reset
    repeat (20) @(negedge clk);

    // 1234 with busy-length measurement
    do_load(1234);
    len = 0;
    while (busy_b && len < 100) begin
      len++;
      @(negedge clk);
    end
    check("busy_len", len, 15);
    repeat (40) @(negedge clk);

    // Small value, saturation and overflow clearing
    do_load(7);     repeat (40) @(negedge clk);
    do_load(12000); repeat (40) @(negedge clk);
    do_load(42);    repeat (40) @(negedge clk);

    // Load during busy is ignored
    do_load(500);
    repeat (4) @(negedge clk);
    load = 1'b1; value_in = 14'd9;
    @(negedge clk);
    load = 1'b0;
    repeat (40) @(negedge clk);

    // Reset in the middle of a conversion
    do_load(8888);
    repeat (6) @(negedge clk);
    #2;
    chk_en = 1'b0;
    reset  = 1'b1;
    #1;
    check("rst_busy", busy_b, 0);
    check("rst_ovf",  ovf_b,  0);
    check("rst_dig",  dig_b,  0);
    check("rst_gnd",  gnd_b,  15);
    check("rst_gnd_n", gnd_n, 15);
    @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    repeat (24) @(negedge clk);

    // Boundary values
    do_load(9999);  repeat (20) @(negedge clk);
    do_load(10000); repeat (20) @(negedge clk);
    do_load(0);     repeat (20) @(negedge clk);

    // Randomized loads, gaps and held load strobes
    repeat (80) begin
      @(negedge clk);
      load     = 1'b1;
      value_in = 14'($urandom_range(0, 16383));
      repeat ($urandom_range(1, 20)) begin
        @(negedge clk);
        if ($urandom_range(0, 3) == 0) value_in = 14'($urandom_range(0, 16383));
      end
      load = 1'b0;
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_display_scanner
`default_nettype wire
